// File: rtl/fp_mult_pkg.sv
// Shared types and helpers for the parametrised floating-point multiplier.
// The encoding helpers take the field widths as arguments, so other FP units can reuse them.
package fp_mult_pkg;

  // Operand classification. Subnormals are flushed and report as zero.
  typedef enum logic [1:0] {
    ClsZero,
    ClsNorm,
    ClsInf,
    ClsNan
  } fp_class_e;

  // Bit positions inside the 4-bit flags vector {exception, overflow, underflow, inexact}.
  localparam int unsigned FlagInexact   = 0;
  localparam int unsigned FlagUnderflow = 1;
  localparam int unsigned FlagOverflow  = 2;
  localparam int unsigned FlagException = 3;
  localparam int unsigned FlagW         = 4;

  // Exponent bias, 2^(exp_w-1)-1.
  function automatic int unsigned exp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // All-ones exponent pattern, zero-extended to 64 bits.
  function automatic logic [63:0] exp_ones(input int unsigned exp_w);
    return (64'd1 << exp_w) - 64'd1;
  endfunction

  // Canonical quiet NaN {0, all-ones, 1, 0...}, zero-extended to 128 bits.
  function automatic logic [127:0] canon_nan(input int unsigned exp_w, input int unsigned man_w);
    logic [127:0] r;
    r = ((128'd1 << exp_w) - 128'd1) << man_w;
    r = r | (128'd1 << (man_w - 1));
    return r;
  endfunction

  // Classify one operand from its decoded exponent and mantissa properties.
  function automatic fp_class_e classify(input logic exp_is_zero, input logic exp_is_ones,
                                         input logic man_nonzero);
    fp_class_e c;
    if (exp_is_zero) begin
      c = ClsZero;
    end else if (exp_is_ones) begin
      c = man_nonzero ? ClsNan : ClsInf;
    end else begin
      c = ClsNorm;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational normalise / round / pack stage for a floating-point product.
// Resolves special operand classes, applies round-to-nearest-even (or truncation when rtz=1)
// and produces the packed result plus {exception, overflow, underflow, inexact} flags.
module fp_round_pack
  import fp_mult_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     sign,
  input  fp_class_e                cls_a,
  input  fp_class_e                cls_b,
  input  logic [2*MAN_W+1:0]       prod,
  input  logic signed [EXP_W+1:0]  esum,
  input  logic                     rtz,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [FlagW-1:0]         flags
);

  localparam int unsigned PROD_W = 2 * MAN_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(exp_ones(EXP_W));
  localparam logic [EXP_W+MAN_W:0] CANON_NAN = (EXP_W + MAN_W + 1)'(canon_nan(EXP_W, MAN_W));

  logic                    msb;
  logic [MAN_W-1:0]        mant;
  logic                    guard;
  logic                    sticky;
  logic                    inc;
  logic [MAN_W:0]          man_sum;
  logic signed [EXP_W+1:0] exp_n;
  logic signed [EXP_W+1:0] exp_f;
  logic                    ovf;
  logic                    unf;
  logic                    any_nan;
  logic                    any_inf;
  logic                    any_zero;

  // Normalise the product, round, then pick the result by class priority.
  always_comb begin
    msb = prod[PROD_W-1];
    if (msb) begin
      mant   = prod[PROD_W-2 -: MAN_W];
      guard  = prod[MAN_W];
      sticky = |prod[MAN_W-1:0];
    end else begin
      mant   = prod[PROD_W-3 -: MAN_W];
      guard  = prod[MAN_W-1];
      sticky = |prod[MAN_W-2:0];
    end

    inc     = !rtz && guard && (sticky || mant[0]);
    // A carry out of the mantissa leaves the low bits at zero, which is the renormalised value.
    man_sum = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
    exp_n   = esum + {{(EXP_W + 1){1'b0}}, msb};
    exp_f   = exp_n + {{(EXP_W + 1){1'b0}}, man_sum[MAN_W]};

    ovf = !exp_f[EXP_W+1] && (exp_f[EXP_W:0] >= {1'b0, EXP_ONES});
    unf = exp_f[EXP_W+1] || (exp_f == '0);

    any_inf  = (cls_a == ClsInf) || (cls_b == ClsInf);
    any_zero = (cls_a == ClsZero) || (cls_b == ClsZero);
    any_nan  = (cls_a == ClsNan) || (cls_b == ClsNan) || (any_inf && any_zero);

    result = {sign, exp_f[EXP_W-1:0], man_sum[MAN_W-1:0]};
    flags  = '0;
    if (any_nan) begin
      result = CANON_NAN;
      flags[FlagException] = 1'b1;
    end else if (any_inf) begin
      result = {sign, EXP_ONES, {MAN_W{1'b0}}};
      flags[FlagException] = 1'b1;
    end else if (any_zero) begin
      result = {sign, {(EXP_W + MAN_W){1'b0}}};
    end else if (ovf) begin
      // Truncating rounding saturates to the largest finite magnitude instead of infinity.
      result = rtz ? {sign, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}}
                   : {sign, EXP_ONES, {MAN_W{1'b0}}};
      flags[FlagOverflow] = 1'b1;
      flags[FlagInexact]  = 1'b1;
    end else if (unf) begin
      result = {sign, {(EXP_W + MAN_W){1'b0}}};
      flags[FlagUnderflow] = 1'b1;
      flags[FlagInexact]   = 1'b1;
    end else begin
      flags[FlagInexact] = guard || sticky;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// 3-stage pipelined floating-point multiplier with valid/ready handshake and a pass-through tag.
// Stage 1 unpacks and classifies, stage 2 multiplies significands, stage 3 rounds and packs.
// The whole pipe advances as one unit, so a stalled output freezes every stage.
// Optional build macro FP_MULT_ROUND_MODE_EN adds the in_rnd port (0=RNE, 1=RTZ);
// without it rounding is always round-to-nearest-even.
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
`ifdef FP_MULT_ROUND_MODE_EN
  input  logic                   in_rnd,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [TAG_W-1:0]       out_tag,
  output logic [FlagW-1:0]       out_flags
);

  localparam int unsigned W      = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned PROD_W = 2 * MAN_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(exp_ones(EXP_W));
  localparam logic signed [EXP_W+1:0] BIAS = (EXP_W + 2)'(exp_bias(EXP_W));

  logic advance;
  logic rnd_c;

  // Unpacked operand fields.
  logic [EXP_W-1:0]        ea;
  logic [EXP_W-1:0]        eb;
  logic [MAN_W-1:0]        ma;
  logic [MAN_W-1:0]        mb;
  fp_class_e               cls_a_c;
  fp_class_e               cls_b_c;
  logic signed [EXP_W+1:0] esum_c;

  // Stage 1 registers.
  logic                    s1_valid;
  logic                    s1_sign;
  fp_class_e               s1_cls_a;
  fp_class_e               s1_cls_b;
  logic [SIG_W-1:0]        s1_sig_a;
  logic [SIG_W-1:0]        s1_sig_b;
  logic signed [EXP_W+1:0] s1_esum;
  logic [TAG_W-1:0]        s1_tag;
  logic                    s1_rnd;

  // Stage 2 registers.
  logic                    s2_valid;
  logic                    s2_sign;
  fp_class_e               s2_cls_a;
  fp_class_e               s2_cls_b;
  logic [PROD_W-1:0]       s2_prod;
  logic signed [EXP_W+1:0] s2_esum;
  logic [TAG_W-1:0]        s2_tag;
  logic                    s2_rnd;

  logic [W-1:0]            rp_result;
  logic [FlagW-1:0]        rp_flags;

`ifdef FP_MULT_ROUND_MODE_EN
  assign rnd_c = in_rnd;
`else
  assign rnd_c = 1'b0;
`endif

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Field extraction, classification and biased exponent sum for stage 1.
  always_comb begin
    ea      = in_a[W-2 -: EXP_W];
    eb      = in_b[W-2 -: EXP_W];
    ma      = in_a[MAN_W-1:0];
    mb      = in_b[MAN_W-1:0];
    cls_a_c = classify(ea == '0, ea == EXP_ONES, ma != '0);
    cls_b_c = classify(eb == '0, eb == EXP_ONES, mb != '0);
    esum_c  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
  end

  // Stage 1: register unpacked operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls_a <= ClsZero;
      s1_cls_b <= ClsZero;
      s1_sig_a <= '0;
      s1_sig_b <= '0;
      s1_esum  <= '0;
      s1_tag   <= '0;
      s1_rnd   <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_sign  <= in_a[W-1] ^ in_b[W-1];
      s1_cls_a <= cls_a_c;
      s1_cls_b <= cls_b_c;
      s1_sig_a <= {1'b1, ma};
      s1_sig_b <= {1'b1, mb};
      s1_esum  <= esum_c;
      s1_tag   <= in_tag;
      s1_rnd   <= rnd_c;
    end
  end

  // Stage 2: full-width significand product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_cls_a <= ClsZero;
      s2_cls_b <= ClsZero;
      s2_prod  <= '0;
      s2_esum  <= '0;
      s2_tag   <= '0;
      s2_rnd   <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_cls_a <= s1_cls_a;
      s2_cls_b <= s1_cls_b;
      s2_prod  <= PROD_W'(s1_sig_a) * PROD_W'(s1_sig_b);
      s2_esum  <= s1_esum;
      s2_tag   <= s1_tag;
      s2_rnd   <= s1_rnd;
    end
  end

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .sign   (s2_sign),
    .cls_a  (s2_cls_a),
    .cls_b  (s2_cls_b),
    .prod   (s2_prod),
    .esum   (s2_esum),
    .rtz    (s2_rnd),
    .result (rp_result),
    .flags  (rp_flags)
  );

  // Stage 3: output register, held while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_flags  <= '0;
    end else if (advance) begin
      out_valid  <= s2_valid;
      out_result <= rp_result;
      out_tag    <= s2_tag;
      out_flags  <= rp_flags;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe (binary32 defaults). Expected responses are queued at
// issue time, from the directed table or from an integer-arithmetic reference model, and a
// separate monitor pops and compares them as results leave the DUT.
module tb_fp_mult_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;

  logic        stall_req;
  logic        rand_ready;
  logic        rnd_bit;

  int          n_checks;
  int          n_fail;
  int          n_pops;
  int          cyc;
  int          acc_cyc;
  logic [39:0] exp_q[$];

  fp_mult_pipe #(
    .EXP_W (8),
    .MAN_W (23),
    .TAG_W (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
`ifdef FP_MULT_ROUND_MODE_EN
    .in_rnd     (1'b0),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

  assign out_ready = stall_req ? 1'b0 : (rand_ready ? rnd_bit : 1'b1);

  // Directed vectors: {a, b, result, flags}
  logic [31:0] d_a[8] = '{32'h40000000, 32'h3FC00000, 32'h3F800800, 32'h3F800001,
                          32'h7F000000, 32'h00800000, 32'h7F800000, 32'hFF800000};
  logic [31:0] d_b[8] = '{32'h40400000, 32'h3FC00000, 32'h3F800800, 32'h3F800001,
                          32'h7F000000, 32'h00800000, 32'h00000000, 32'h40000000};
  logic [31:0] d_r[8] = '{32'h40C00000, 32'h40100000, 32'h3F801000, 32'h3F800002,
                          32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000};
  logic [3:0]  d_f[8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                          4'b0101, 4'b0011, 4'b1000, 4'b1000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer product, rounded to 24 significant bits by remainder comparison.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f);
    int ea, eb, e, k;
    longint unsigned ma, mb, p, q, rem, half;
    logic s;
    bit za, zb, ia, ib, na, nb;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (ma == 0);
    ib = (eb == 255) && (mb == 0);
    na = (ea == 255) && (ma != 0);
    nb = (eb == 255) && (mb != 0);
    s  = a[31] ^ b[31];
    f  = 4'b0000;
    if (na || nb || (ia && zb) || (ib && za)) begin
      r = 32'h7FC00000;
      f = 4'b1000;
    end else if (ia || ib) begin
      r = {s, 8'hFF, 23'h0};
      f = 4'b1000;
    end else if (za || zb) begin
      r = {s, 31'h0};
    end else begin
      p = (ma + 64'h80_0000) * (mb + 64'h80_0000);
      e = ea + eb - 127;
      if (p >= 64'h8000_0000_0000) begin
        k = 24;
        e = e + 1;
      end else begin
        k = 23;
      end
      q    = p >> k;
      rem  = p - (q << k);
      half = 64'd1 << (k - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == 64'h100_0000) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        f = 4'b0011;
      end else begin
        r = {s, e[7:0], q[22:0]};
        f = {3'b000, rem != 0};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    int unsigned sel;
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    sel = $urandom_range(0, 99);
    s   = 1'($urandom_range(0, 1));
    m   = 23'($urandom);
    if (sel < 55) begin
      e = 8'($urandom_range(90, 165));
    end else if (sel < 75) begin
      e = 8'($urandom_range(1, 254));
    end else if (sel < 80) begin
      e = 8'd0;
      m = 23'd0;
    end else if (sel < 84) begin
      e = 8'd0;
    end else if (sel < 88) begin
      e = 8'hFF;
      m = 23'd0;
    end else if (sel < 92) begin
      e = 8'hFF;
      m = m | 23'd1;
    end else begin
      // Sparse mantissas make exact ties and mantissa carries likely.
      e = 8'($urandom_range(100, 150));
      m = m & 23'h7FF800;
    end
    return {s, e, m};
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                      input logic [31:0] er, input logic [3:0] ef);
    int tries;
    tries = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    #1;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      #1;
      tries++;
    end
    check("send_accept", {63'd0, in_ready}, 64'd1);
    if (in_ready) begin
      exp_q.push_back({er, tag, ef});
      acc_cyc = cyc;
    end
  endtask

  task automatic send_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    logic [31:0] r;
    logic [3:0]  f;
    ref_mul(a, b, r, f);
    send(a, b, tag, r, f);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: handshake rule every cycle, scoreboard pop on each output transfer.
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        check("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: actual=%h tag=%h expected=none",
                     out_result, out_tag);
          end else begin
            e = exp_q.pop_front();
            check("result_tag_flags", {24'd0, out_result, out_tag, out_flags}, {24'd0, e});
            n_pops++;
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_acc;
    int n;
    int pops_before;
    n_checks   = 0;
    n_fail     = 0;
    n_pops     = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_tag     = '0;
    stall_req  = 1'b0;
    rand_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_result", {32'd0, out_result}, 64'd0);
    check("rst_out_tag", {60'd0, out_tag}, 64'd0);
    check("rst_out_flags", {60'd0, out_flags}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Latency of a lone op.
    send(d_a[0], d_b[0], 4'd5, d_r[0], d_f[0]);
    t_acc = acc_cyc;
    idle();
    n = 0;
    #1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("latency", 64'(cyc - t_acc), 64'd3);
    drain();

    // Remaining directed vectors.
    for (int i = 1; i < 8; i++) send(d_a[i], d_b[i], 4'(i), d_r[i], d_f[i]);
    idle();
    drain();

    // Backpressure: six back-to-back ops, consumer stalls for five cycles.
    pops_before = n_pops;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send_model({1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)},
                     {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)},
                     4'(i));
        end
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        stall_req = 1'b1;
        for (int j = 0; j < 5; j++) begin
          #1;
          check("stall_in_ready", {63'd0, in_ready}, 64'd0);
          @(negedge clk);
        end
        stall_req = 1'b0;
      end
    join
    drain();
    check("bp_count", 64'(n_pops - pops_before), 64'd6);

    // Reset with ops in flight: everything is dropped, nothing stale appears afterwards.
    pops_before = n_pops;
    for (int i = 1; i < 4; i++) send_model(rand_op(), rand_op(), 4'(i));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_reset_out_valid", {63'd0, out_valid}, 64'd1);
    reset = 1'b1;
    #1;
    check("reset_drops_out_valid", {63'd0, out_valid}, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("post_reset_quiet", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
    end
    check("reset_no_pops", 64'(n_pops - pops_before), 64'd0);

    // Random traffic against the reference model with random consumer stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send_model(rand_op(), rand_op(), 4'($urandom));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain();
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
